// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Register-address width, register count, default data width and the x0 address.
// Also holds the hazard lookup used by the scoreboard's three query ports.
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  // A register is "busy" if a write is outstanding in the scoreboard, or if the
  // write has already left the arbiter but is still sitting in the output
  // stage (the register file only captures it at the end of that cycle).
  function automatic logic hazard_hit(
    input logic [REG_ADDR_W-1:0] r,
    input logic [NUM_REGS-1:0]   busy,
    input logic                  byp_we,
    input logic [REG_ADDR_W-1:0] byp_rd
  );
    return (r != X0) && (busy[r] || (byp_we && (byp_rd == r)));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
// Latency: set/clear take effect at the next clk edge; lookups are combinational.
// Backpressure: none; set and clear are accepted every cycle, set wins on a tie.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset (clears all bits)
//   set_vld_i / set_rd_i      mark a register as having an outstanding write
//   clr_vld_i / clr_rd_i      retire the outstanding write of a register
//   byp_we_i / byp_rd_i       write currently held in the output stage
//   rs1_i, rs2_i              decode source registers to check
//   issue_vld_i, issue_rd_i   destination of the instruction being issued
//   rs1_busy_o, rs2_busy_o    source has an outstanding write
//   issue_conflict_o          issue destination already has an outstanding write
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_vld_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_vld_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic                  byp_we_i,
  input  logic [REG_ADDR_W-1:0] byp_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  issue_vld_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic                  issue_conflict_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first, then set, so an issue and a retirement of the same register
  // in one cycle leave the newer write outstanding.
  always_comb begin
    busy_d = busy_q;
    if (clr_vld_i) begin
      busy_d[clr_rd_i] = 1'b0;
    end
    if (set_vld_i && (set_rd_i != X0)) begin
      busy_d[set_rd_i] = 1'b1;
    end
    busy_d[X0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o       = hazard_hit(rs1_i, busy_q, byp_we_i, byp_rd_i);
  assign rs2_busy_o       = hazard_hit(rs2_i, busy_q, byp_we_i, byp_rd_i);
  assign issue_conflict_o = issue_vld_i && hazard_hit(issue_rd_i, busy_q, byp_we_i, byp_rd_i);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the ALU/load path (req0) and the mul/div unit (req1) onto the RF write port.
// Latency: a grant in cycle N appears on rf_A3/rf_WD/rf_We in cycle N+1.
// Backpressure: valid/ready, ready is combinational from the grant; req0 has priority
//   but req1 is forced through after STARVE_LIMIT consecutive lost cycles.
//
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   req0_valid/rd/data, req0_ready         source 0 (ALU/load) writeback request
//   req1_valid/rd/data, req1_ready         source 1 (mul/div) writeback request
//   issue_valid, issue_rd                  decode issuing an instruction that writes issue_rd
//   rs1, rs2, rs1_busy, rs2_busy           decode RAW hazard lookups
//   issue_conflict                         decode WAW hazard lookup
//   rf_A3, rf_WD, rf_We                    register file write port
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int XLEN         = rf_wb_arbiter_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_rd,
  input  logic [XLEN-1:0]       req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_rd,
  input  logic [XLEN-1:0]       req1_data,
  output logic                  req1_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  issue_conflict,
  output logic [REG_ADDR_W-1:0] rf_A3,
  output logic [XLEN-1:0]       rf_WD,
  output logic                  rf_We
);

  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]      starve_q;
  logic [CNT_W-1:0]      starve_d;
  logic                  grant0;
  logic                  grant1;
  logic                  grant_any;
  logic [REG_ADDR_W-1:0] grant_rd;
  logic [XLEN-1:0]       grant_data;

  logic [REG_ADDR_W-1:0] a3_q;
  logic [XLEN-1:0]       wd_q;
  logic                  we_q;

  // req0 wins a tie unless req1 has already lost STARVE_MAX cycles in a row.
  // Nothing is granted while reset is asserted.
  assign grant0 = !rst && req0_valid && !(req1_valid && (starve_q >= STARVE_MAX));
  assign grant1 = !rst && req1_valid && !grant0;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign grant_any  = grant0 || grant1;
  assign grant_rd   = grant0 ? req0_rd   : req1_rd;
  assign grant_data = grant0 ? req0_data : req1_data;

  // Counts consecutive cycles req1 waits while valid; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!req1_valid || grant1) begin
      starve_d = '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Output stage: address/data hold when idle, only the write enable drops.
  // x0 writes still take the slot but never enable the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      a3_q <= X0;
      wd_q <= '0;
      we_q <= 1'b0;
    end else if (grant_any) begin
      a3_q <= grant_rd;
      wd_q <= grant_data;
      we_q <= (grant_rd != X0);
    end else begin
      we_q <= 1'b0;
    end
  end

  assign rf_A3 = a3_q;
  assign rf_WD = wd_q;
  assign rf_We = we_q;

  rf_scoreboard u_scoreboard (
    .clk              (clk),
    .rst              (rst),
    .set_vld_i        (issue_valid),
    .set_rd_i         (issue_rd),
    .clr_vld_i        (grant_any),
    .clr_rd_i         (grant_rd),
    .byp_we_i         (we_q),
    .byp_rd_i         (a3_q),
    .rs1_i            (rs1),
    .rs2_i            (rs2),
    .issue_vld_i      (issue_valid),
    .issue_rd_i       (issue_rd),
    .rs1_busy_o       (rs1_busy),
    .rs2_busy_o       (rs2_busy),
    .issue_conflict_o (issue_conflict)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic.
// A reference model samples inputs each negedge, checks ready/hazard outputs and
// queues the expected RF port contents; a monitor pops them after the next posedge.
module tb_rf_wb_arbiter;

  localparam int LIMIT = 3;

  typedef struct packed {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        issue_valid;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy, issue_conflict;
  logic [4:0]  rf_A3;
  logic [31:0] rf_WD;
  logic        rf_We;

  int pass_cnt = 0;
  int total_cnt = 0;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_conflict(issue_conflict),
    .rf_A3(rf_A3), .rf_WD(rf_WD), .rf_We(rf_We)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  out_t exp_q[$];
  out_t exp_cur = '0;
  bit   busy_m[32];
  int   losses = 0;          // consecutive cycles req1 has waited
  bit   xfer0, xfer1;        // observed transfers, used by the driver
  bit   log_en = 0;
  int   grant_log[$];

  function automatic bit pending(input logic [4:0] r, input out_t cur);
    if (r == 0) return 0;
    return busy_m[r] || (cur.we && cur.a3 == r);
  endfunction

  always @(negedge clk) begin
    bit   g0, g1;
    out_t nxt;
    xfer0 = req0_valid && req0_ready;
    xfer1 = req1_valid && req1_ready;
    if (rst) begin
      chk("reset_ready0", req0_ready, 0);
      chk("reset_ready1", req1_ready, 0);
      for (int i = 0; i < 32; i++) busy_m[i] = 0;
      losses = 0;
      exp_cur = '0;
      exp_q.push_back('0);
    end else begin
      chk("rs1_busy", rs1_busy, pending(rs1, exp_cur));
      chk("rs2_busy", rs2_busy, pending(rs2, exp_cur));
      chk("issue_conflict", issue_conflict, issue_valid && pending(issue_rd, exp_cur));
      g1 = req1_valid && (!req0_valid || losses >= LIMIT);
      g0 = req0_valid && !g1;
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      if (log_en && (g0 || g1)) grant_log.push_back(g1 ? 1 : 0);
      nxt = exp_cur;
      nxt.we = 0;
      if (g0) nxt = '{we: req0_rd != 0, a3: req0_rd, wd: req0_data};
      if (g1) nxt = '{we: req1_rd != 0, a3: req1_rd, wd: req1_data};
      exp_q.push_back(nxt);
      exp_cur = nxt;
      if (req1_valid && !g1) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
      else losses = 0;
      if (g0) busy_m[req0_rd] = 0;
      if (g1) busy_m[req1_rd] = 0;
      if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1;
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    out_t e;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_We", rf_We, e.we);
      chk("rf_A3", rf_A3, e.a3);
      chk("rf_WD", rf_WD, e.wd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_grants[8];
    exp_grants = '{0, 0, 0, 1, 0, 0, 0, 1};
    rst = 1;
    req0_valid = 1; req0_rd = 5'd3; req0_data = 32'h11;
    req1_valid = 1; req1_rd = 5'd4; req1_data = 32'h22;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    step(); step();
    rst = 0; req0_valid = 0; req1_valid = 0;
    rs1 = 5'd3; rs2 = 5'd4;
    step();

    // single source write
    req0_valid = 1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF; rs1 = 5'd5;
    step();
    req0_valid = 0;
    step(); step();

    // priority and starvation with both sources continuously valid
    req0_valid = 1; req0_rd = 5'd1; req0_data = 32'hA0A0A0A0;
    req1_valid = 1; req1_rd = 5'd2; req1_data = 32'hB1B1B1B1;
    log_en = 1;
    for (int i = 0; i < 8; i++) step();
    log_en = 0;
    req0_valid = 0; req1_valid = 0;
    chk("grant_log_len", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk($sformatf("grant_seq[%0d]", i), grant_log[i], exp_grants[i]);
    step();

    // scoreboard: issue 7, retire it through req1, then WAW while busy
    issue_valid = 1; issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd0;
    step();
    issue_valid = 0;
    step(); step(); step();
    req1_valid = 1; req1_rd = 5'd7; req1_data = 32'hCAFE0007;
    step();
    req1_valid = 0;
    step(); step();
    issue_valid = 1; issue_rd = 5'd7;
    step(); step();
    issue_valid = 0;
    req0_valid = 1; req0_rd = 5'd7; req0_data = 32'h7;
    step();
    req0_valid = 0;
    step();

    // x0 handling
    req0_valid = 1; req0_rd = 5'd0; req0_data = 32'h1234; rs1 = 5'd0;
    step();
    req0_valid = 0; issue_valid = 1; issue_rd = 5'd0;
    step();
    issue_valid = 0;
    step();

    // same-cycle set and clear on register 9
    issue_valid = 1; issue_rd = 5'd9; req0_valid = 1; req0_rd = 5'd9; req0_data = 32'h99;
    rs2 = 5'd9;
    step();
    issue_valid = 0; req0_valid = 0;
    step(); step();

    // random traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      rst = (i == 300 || i == 301);
      if (!req0_valid || xfer0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_rd = 5'($urandom_range(0, 7));
        req0_data = $urandom;
      end
      if (!req1_valid || xfer1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_rd = 5'($urandom_range(0, 7));
        req1_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      step();
    end
    rst = 0; req0_valid = 0; req1_valid = 0; issue_valid = 0;
    step(); step();
    chk("queue_drained", (exp_q.size() <= 1) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Arbitrates two writeback sources onto the single write port (A3/WD/We) of the 32x32 register file. Source 0 is the ALU/load path; source 1 is the multi-cycle unit (mul/div). Also keeps a 32-bit pending-write scoreboard so decode can detect RAW/WAW hazards. It sits between the execute units and the register file write port, and feeds decode stall logic.

Parameters:
STARVE_LIMIT, 3, number of consecutive cycles req1 may be valid and lose before it is forced to win (legal range >= 1)
XLEN, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req0_valid  in  1  source 0 write request
req0_rd  in  5  source 0 destination register
req0_data  in  XLEN  source 0 write data
req0_ready  out  1  source 0 request accepted this cycle
req1_valid  in  1  source 1 write request
req1_rd  in  5  source 1 destination register
req1_data  in  XLEN  source 1 write data
req1_ready  out  1  source 1 request accepted this cycle
issue_valid  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  5  destination of the issued instruction
rs1, rs2  in  5  decode source registers to check
rs1_busy, rs2_busy  out  1  source has an outstanding write
issue_conflict  out  1  issue_rd already has an outstanding write (WAW)
rf_A3  out  5  to register file A3
rf_WD  out  XLEN  to register file WD
rf_We  out  1  to register file We

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state changes on posedge clk.
- Reset values: busy[31:0]=0, starve_cnt=0, rf_We=0, rf_A3=0, rf_WD=0. While rst=1, req0_ready=req1_ready=0 and no grant occurs.
- Handshake: valid/ready. readyX is combinational from the current grant. A transfer happens when validX && readyX. After the source raises valid, rd/data must stay stable until ready. Ready may be asserted in the same cycle valid rises.
- Arbitration, one grant per cycle:
  - Only one valid: that source is granted.
  - Both valid: req0 wins unless starve_cnt >= STARVE_LIMIT, in which case req1 wins.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - Cleared when req1 is granted or req1_valid=0.
  - Otherwise increments when req1_valid && !req1_ready, saturating at STARVE_LIMIT.
- Output stage is registered with 1-cycle latency:
  - Grant in cycle N drives rf_A3/rf_WD from the winner's rd/data in cycle N+1.
  - rf_We=1 in cycle N+1 if winner rd != 0, else rf_We=0.
  - The register file captures the write at the end of cycle N+1.
  - With no grant, rf_We=0 and rf_A3/rf_WD hold their previous values.
- rd=0 requests are granted normally (they consume the slot), but never assert rf_We.
- Scoreboard:
  - issue_valid && issue_rd != 0 sets busy[issue_rd].
  - A granted request clears busy[rd] at the grant edge.
  - Set and clear on the same rd in the same cycle: set wins.
  - busy[0] is constantly 0.
- rsX_busy = (rsX != 0) && (busy[rsX] || (rf_We && rf_A3 == rsX)). This covers the write that is granted but not yet in the register file.
- issue_conflict = issue_valid && issue_rd != 0 && rsbusy-style check on issue_rd (same formula as rsX_busy). Combinational, informational; the bit remains set.
- Reset mid-operation: any grant pending in the output stage is dropped (rf_We=0 next cycle), the scoreboard is cleared, and sources re-present after reset.

Decomposition:
- Shared package: REG_ADDR_W=5, NUM_REGS=32, XLEN, X0 constant 5'd0.
- One natural sub-module: rf_scoreboard. It holds busy[31:0] with set/clear ports and three combinational lookup ports (rs1, rs2, issue_rd) plus the output-stage bypass inputs.
- Arbiter, starvation counter and output register stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with both valid=1 -> ready0=ready1=0; rf_We=0, rf_A3=0, rf_WD=0; after release all busy=0.
- Single source: req0 rd=5, data=0xDEADBEEF in cycle N -> req0_ready=1 in N; in N+1 rf_We=1, rf_A3=5, rf_WD=0xDEADBEEF; in N+2 rf_We=0.
- Priority/starvation (STARVE_LIMIT=3): both valid continuously -> grants 0,0,0,1,0,0,0,1; starve_cnt returns to 0 after each req1 grant.
- Scoreboard:
  - issue rd=7 in cycle 0 -> rs1=7 gives rs1_busy=1.
  - req1 rd=7 granted in cycle 4 -> rs1_busy stays 1 in cycle 5 (bypass term), drops to 0 in cycle 6.
  - issue rd=7 again while busy -> issue_conflict=1.
- Same-cycle set/clear: issue rd=9 and grant rd=9 in the same cycle -> busy[9]=1 afterwards.
- x0: req0 rd=0 data=0x1234 -> req0_ready=1, rf_We=0 next cycle; issue rd=0 -> busy unchanged, issue_conflict=0; rs1=0 -> rs1_busy=0.
